// File: rtl/dds_pkg.sv
// Shared types and defaults for the DDS frequency sweep controller.
package dds_pkg;

    localparam int FW_DEFAULT = 16;
    localparam int DW_DEFAULT = 24;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/dds_dwell_timer.sv
// Dwell down-counter: load a hold count, count down while enabled,
// and flag expiry in the cycle the count sits at zero.
module dds_dwell_timer
    import dds_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          load,
    input  logic          en,
    input  logic [DW-1:0] load_val,
    output logic          expire
);

    logic [DW-1:0] cnt_r;
    logic          at_zero_s;

    assign at_zero_s = (cnt_r == {DW{1'b0}});
    assign expire    = en & at_zero_s;

    // Counter register: a load wins over counting.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_r <= {DW{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (en && !at_zero_s) begin
            cnt_r <= cnt_r - {{(DW-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency sweep controller feeding a DDS with frequency and phase words.
// Define DDS_SWEEP_TRIANGLE_EN for triangle sweeps; sawtooth otherwise.
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int FW = FW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [FW-1:0] cfg_start_freq,
    input  logic [FW-1:0] cfg_stop_freq,
    input  logic [FW-1:0] cfg_step,
    input  logic [DW-1:0] cfg_dwell,
    input  logic          cfg_continuous,
    input  logic [FW-1:0] cfg_phase,
    output logic [FW-1:0] freq_word,
    output logic [FW-1:0] phase_word,
    output logic          busy,
    output logic          step_strobe,
    output logic          sweep_done
);

    state_e        state_r, state_nxt_s;
    dir_e          dir_r, dir_nxt_s;
    logic [FW-1:0] freq_r, freq_nxt_s;
    logic [FW-1:0] phase_r, phase_nxt_s;
    logic          busy_r, strobe_r, done_r;
    logic          strobe_nxt_s, done_nxt_s, capture_s;
    logic [FW-1:0] start_sh_r, stop_sh_r, step_sh_r;
    logic [DW-1:0] dwell_sh_r;
    logic          cont_sh_r;
    logic          expire_s;
    logic [DW-1:0] load_val_s;
`ifdef DDS_SWEEP_TRIANGLE_EN
    logic          leg_r, leg_nxt_s;
    dir_e          dir_inv_s;
    logic [FW-1:0] target_s;
    dir_e          move_dir_s;
`endif

    // Saturating step toward target using one extra bit, so neither end can wrap.
    function automatic logic [FW-1:0] step_toward(input logic [FW-1:0] cur,
                                                  input logic [FW-1:0] stp,
                                                  input logic [FW-1:0] tgt,
                                                  input dir_e          dir);
        logic [FW:0]   ext;
        logic [FW-1:0] res;
        if (dir == DIR_UP) begin
            ext = {1'b0, cur} + {1'b0, stp};
            res = (ext > {1'b0, tgt}) ? tgt : ext[FW-1:0];
        end else begin
            ext = {1'b0, cur} - {1'b0, stp};
            res = (ext[FW] || (ext[FW-1:0] < tgt)) ? tgt : ext[FW-1:0];
        end
        return res;
    endfunction

    assign load_val_s = capture_s ? cfg_dwell : dwell_sh_r;

    dds_dwell_timer #(.DW(DW)) u_dwell_timer (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .load      (strobe_nxt_s),
        .en        (state_r == ST_RUN),
        .load_val  (load_val_s),
        .expire    (expire_s)
    );

`ifdef DDS_SWEEP_TRIANGLE_EN
    assign dir_inv_s  = (dir_r == DIR_UP) ? DIR_DOWN : DIR_UP;
    assign target_s   = leg_r ? start_sh_r : stop_sh_r;
    assign move_dir_s = leg_r ? dir_inv_s : dir_r;
`endif

    // Next-state and next-output decode; abort outranks start and dwell expiry.
    always_comb begin
        state_nxt_s  = state_r;
        dir_nxt_s    = dir_r;
        freq_nxt_s   = freq_r;
        phase_nxt_s  = phase_r;
        strobe_nxt_s = 1'b0;
        done_nxt_s   = 1'b0;
        capture_s    = 1'b0;
`ifdef DDS_SWEEP_TRIANGLE_EN
        leg_nxt_s    = leg_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (start && !abort) begin
                    capture_s    = 1'b1;
                    state_nxt_s  = ST_RUN;
                    freq_nxt_s   = cfg_start_freq;
                    phase_nxt_s  = cfg_phase;
                    strobe_nxt_s = 1'b1;
                    dir_nxt_s    = (cfg_start_freq > cfg_stop_freq) ? DIR_DOWN : DIR_UP;
`ifdef DDS_SWEEP_TRIANGLE_EN
                    leg_nxt_s    = 1'b0;
`endif
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_nxt_s = ST_IDLE;
                end else if (expire_s) begin
`ifdef DDS_SWEEP_TRIANGLE_EN
                    if (freq_r != target_s) begin
                        freq_nxt_s   = step_toward(freq_r, step_sh_r, target_s, move_dir_s);
                        strobe_nxt_s = 1'b1;
                    end else if (!leg_r && (start_sh_r != stop_sh_r)) begin
                        leg_nxt_s    = 1'b1;
                        freq_nxt_s   = step_toward(freq_r, step_sh_r, start_sh_r, dir_inv_s);
                        strobe_nxt_s = 1'b1;
                    end else if (cont_sh_r) begin
                        leg_nxt_s    = 1'b0;
                        freq_nxt_s   = (start_sh_r == stop_sh_r) ? start_sh_r :
                                       step_toward(freq_r, step_sh_r, stop_sh_r, dir_r);
                        strobe_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_DONE;
                        done_nxt_s  = 1'b1;
                    end
`else
                    if (freq_r != stop_sh_r) begin
                        freq_nxt_s   = step_toward(freq_r, step_sh_r, stop_sh_r, dir_r);
                        strobe_nxt_s = 1'b1;
                    end else if (cont_sh_r) begin
                        freq_nxt_s   = start_sh_r;
                        strobe_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_DONE;
                        done_nxt_s  = 1'b1;
                    end
`endif
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, output and shadow registers; a zero step is stored as one.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r    <= ST_IDLE;
            dir_r      <= DIR_UP;
            freq_r     <= {FW{1'b0}};
            phase_r    <= {FW{1'b0}};
            busy_r     <= 1'b0;
            strobe_r   <= 1'b0;
            done_r     <= 1'b0;
            start_sh_r <= {FW{1'b0}};
            stop_sh_r  <= {FW{1'b0}};
            step_sh_r  <= {FW{1'b0}};
            dwell_sh_r <= {DW{1'b0}};
            cont_sh_r  <= 1'b0;
`ifdef DDS_SWEEP_TRIANGLE_EN
            leg_r      <= 1'b0;
`endif
        end else begin
            state_r  <= state_nxt_s;
            dir_r    <= dir_nxt_s;
            freq_r   <= freq_nxt_s;
            phase_r  <= phase_nxt_s;
            busy_r   <= (state_nxt_s == ST_RUN);
            strobe_r <= strobe_nxt_s;
            done_r   <= done_nxt_s;
`ifdef DDS_SWEEP_TRIANGLE_EN
            leg_r    <= leg_nxt_s;
`endif
            if (capture_s) begin
                start_sh_r <= cfg_start_freq;
                stop_sh_r  <= cfg_stop_freq;
                step_sh_r  <= (cfg_step == {FW{1'b0}}) ? {{(FW-1){1'b0}}, 1'b1} : cfg_step;
                dwell_sh_r <= cfg_dwell;
                cont_sh_r  <= cfg_continuous;
            end else begin
                start_sh_r <= start_sh_r;
                stop_sh_r  <= stop_sh_r;
                step_sh_r  <= step_sh_r;
                dwell_sh_r <= dwell_sh_r;
                cont_sh_r  <= cont_sh_r;
            end
        end
    end

    assign freq_word   = freq_r;
    assign phase_word  = phase_r;
    assign busy        = busy_r;
    assign step_strobe = strobe_r;
    assign sweep_done  = done_r;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl against a word-list sweep model.
module tb_dds_sweep_ctrl;

    localparam int FW = 16;
    localparam int DW = 24;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [FW-1:0] cfg_start_freq = '0;
    logic [FW-1:0] cfg_stop_freq = '0;
    logic [FW-1:0] cfg_step = '0;
    logic [DW-1:0] cfg_dwell = '0;
    logic          cfg_continuous = 1'b0;
    logic [FW-1:0] cfg_phase = '0;
    logic [FW-1:0] freq_word;
    logic [FW-1:0] phase_word;
    logic          busy;
    logic          step_strobe;
    logic          sweep_done;

    int tests_run = 0;
    int tests_failed = 0;
    int exp_q[$];

    dds_sweep_ctrl #(.FW(FW), .DW(DW)) dut (
        .sys_clk        (sys_clk),
        .sys_rst_n      (sys_rst_n),
        .start          (start),
        .abort          (abort),
        .cfg_start_freq (cfg_start_freq),
        .cfg_stop_freq  (cfg_stop_freq),
        .cfg_step       (cfg_step),
        .cfg_dwell      (cfg_dwell),
        .cfg_continuous (cfg_continuous),
        .cfg_phase      (cfg_phase),
        .freq_word      (freq_word),
        .phase_word     (phase_word),
        .busy           (busy),
        .step_strobe    (step_strobe),
        .sweep_done     (sweep_done)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    function automatic int step_to(input int w, input int stp, input int tgt);
        if (w < tgt) return (w + stp > tgt) ? tgt : w + stp;
        if (w > tgt) return (w - stp < tgt) ? tgt : w - stp;
        return w;
    endfunction

    // One sweep (or one repeating period) as the list of words the DDS should see.
    task automatic build_period(input int s, input int e, input int st, input bit cont);
        int stp;
        int w;
        stp = (st == 0) ? 1 : st;
        w = s;
        exp_q.delete();
        exp_q.push_back(w);
        while (w != e) begin
            w = step_to(w, stp, e);
            exp_q.push_back(w);
        end
`ifdef DDS_SWEEP_TRIANGLE_EN
        while (w != s) begin
            w = step_to(w, stp, s);
            exp_q.push_back(w);
        end
        if (cont && s != e) void'(exp_q.pop_back());
`else
        if (cont) w = s;
`endif
    endtask

    task automatic launch(input int s, input int e, input int st, input int dw,
                          input bit cont, input int ph);
        cfg_start_freq = FW'(s);
        cfg_stop_freq  = FW'(e);
        cfg_step       = FW'(st);
        cfg_dwell      = DW'(dw);
        cfg_continuous = cont;
        cfg_phase      = FW'(ph);
        abort = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg_start_freq = FW'($urandom);
        cfg_stop_freq  = FW'($urandom);
        cfg_step       = FW'($urandom);
        cfg_dwell      = DW'($urandom);
        cfg_continuous = ($urandom_range(0, 1) == 1);
        cfg_phase      = FW'($urandom);
    endtask

    task automatic test_reset;
        sys_rst_n = 1'b1;
        #1 sys_rst_n = 1'b0;
        #1;
        tests_run++;
        if ({freq_word, phase_word, busy, step_strobe, sweep_done} !== '0) begin
            tests_failed++;
            $display("FAIL reset_state got f=%0d p=%0d b=%b s=%b d=%b want all 0",
                     freq_word, phase_word, busy, step_strobe, sweep_done);
        end
        tick();
        tick();
        sys_rst_n = 1'b1;
        tick();
        tests_run++;
        if ({busy, step_strobe, sweep_done} !== 3'b000) begin
            tests_failed++;
            $display("FAIL idle_after_reset got b=%b s=%b d=%b want 000", busy, step_strobe, sweep_done);
        end
    endtask

    task automatic test_single_sweep(input int s, input int e, input int st, input int dw,
                                     input string name);
        int ph;
        int last;
        logic [2*FW+2:0] exp_v;
        logic [2*FW+2:0] got_v;
        ph = $urandom_range(0, 65535);
        build_period(s, e, st, 1'b0);
        last = exp_q[exp_q.size()-1];
        launch(s, e, st, dw, 1'b0, ph);
        foreach (exp_q[i]) begin
            for (int k = 0; k <= dw; k++) begin
                exp_v = {FW'(exp_q[i]), FW'(ph), 1'b1, (k == 0), 1'b0};
                got_v = {freq_word, phase_word, busy, step_strobe, sweep_done};
                tests_run++;
                if (got_v !== exp_v) begin
                    tests_failed++;
                    $display("FAIL %s word%0d cyc%0d got f=%0d p=%0d b=%b s=%b d=%b want f=%0d p=%0d b=1 s=%b d=0",
                             name, i, k, freq_word, phase_word, busy, step_strobe, sweep_done,
                             exp_q[i], ph, (k == 0));
                end
                start = ($urandom_range(0, 1) == 1);
                tick();
            end
        end
        exp_v = {FW'(last), FW'(ph), 1'b0, 1'b0, 1'b1};
        got_v = {freq_word, phase_word, busy, step_strobe, sweep_done};
        tests_run++;
        if (got_v !== exp_v) begin
            tests_failed++;
            $display("FAIL %s done got f=%0d b=%b s=%b d=%b want f=%0d b=0 s=0 d=1",
                     name, freq_word, busy, step_strobe, sweep_done, last);
        end
        tick();
        start = 1'b0;
        exp_v = {FW'(last), FW'(ph), 1'b0, 1'b0, 1'b0};
        got_v = {freq_word, phase_word, busy, step_strobe, sweep_done};
        tests_run++;
        if (got_v !== exp_v) begin
            tests_failed++;
            $display("FAIL %s idle got f=%0d b=%b s=%b d=%b want f=%0d b=0 s=0 d=0",
                     name, freq_word, busy, step_strobe, sweep_done, last);
        end
        tick();
        tests_run++;
        if ({busy, step_strobe, sweep_done} !== 3'b000) begin
            tests_failed++;
            $display("FAIL %s stays_idle got b=%b s=%b d=%b want 000", name, busy, step_strobe, sweep_done);
        end
    endtask

    task automatic test_random_single;
        int s, e, delta, st, dw, r;
        for (int n = 0; n < 6; n++) begin
            r = $urandom_range(0, 2);
            s = (r == 0) ? $urandom_range(0, 300) :
                (r == 1) ? $urandom_range(65235, 65535) : $urandom_range(0, 65535);
            delta = $urandom_range(0, 200);
            e = ($urandom_range(0, 1) == 1) ? s + delta : s - delta;
            if (e < 0) e = 0;
            if (e > 65535) e = 65535;
            st = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 40);
            dw = $urandom_range(0, 3);
            test_single_sweep(s, e, st, dw, "rand_single");
        end
    endtask

    task automatic test_continuous;
        int ph, dw;
        logic [2*FW+2:0] exp_v;
        logic [2*FW+2:0] got_v;
        ph = $urandom_range(0, 65535);
        dw = $urandom_range(0, 2);
        build_period(65530, 65535, 4, 1'b1);
        launch(65530, 65535, 4, dw, 1'b1, ph);
        for (int p = 0; p < 3; p++) begin
            foreach (exp_q[i]) begin
                for (int k = 0; k <= dw; k++) begin
                    exp_v = {FW'(exp_q[i]), FW'(ph), 1'b1, (k == 0), 1'b0};
                    got_v = {freq_word, phase_word, busy, step_strobe, sweep_done};
                    tests_run++;
                    if (got_v !== exp_v) begin
                        tests_failed++;
                        $display("FAIL continuous p%0d word%0d cyc%0d got f=%0d b=%b s=%b d=%b want f=%0d b=1 s=%b d=0",
                                 p, i, k, freq_word, busy, step_strobe, sweep_done, exp_q[i], (k == 0));
                    end
                    start = ($urandom_range(0, 1) == 1);
                    tick();
                end
            end
        end
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_v = {FW'(exp_q[0]), FW'(ph), 1'b0, 1'b0, 1'b0};
            got_v = {freq_word, phase_word, busy, step_strobe, sweep_done};
            tests_run++;
            if (got_v !== exp_v) begin
                tests_failed++;
                $display("FAIL cont_abort cyc%0d got f=%0d b=%b s=%b d=%b want f=%0d b=0 s=0 d=0",
                         k, freq_word, busy, step_strobe, sweep_done, exp_q[0]);
            end
            tick();
        end
    endtask

    task automatic test_abort;
        int ph;
        int words[5];
        logic [2*FW+2:0] exp_v;
        logic [2*FW+2:0] got_v;
        ph = $urandom_range(0, 65535);
        words = '{1000, 1000, 1000, 1010, 1010};
        launch(1000, 1030, 10, 2, 1'b0, ph);
        for (int c = 0; c < 6; c++) begin
            exp_v = {FW'((c < 3) ? 1000 : 1010), FW'(ph), 1'b1, (c == 0 || c == 3), 1'b0};
            got_v = {freq_word, phase_word, busy, step_strobe, sweep_done};
            tests_run++;
            if (got_v !== exp_v) begin
                tests_failed++;
                $display("FAIL abort_pre cyc%0d got f=%0d b=%b s=%b want f=%0d b=1 s=%b",
                         c, freq_word, busy, step_strobe, (c < 3) ? 1000 : 1010, (c == 0 || c == 3));
            end
            if (c == 5) begin
                abort = 1'b1;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        abort = 1'b0;
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_v = {FW'(words[4]), FW'(ph), 1'b0, 1'b0, 1'b0};
            got_v = {freq_word, phase_word, busy, step_strobe, sweep_done};
            tests_run++;
            if (got_v !== exp_v) begin
                tests_failed++;
                $display("FAIL abort_post cyc%0d got f=%0d p=%0d b=%b s=%b d=%b want f=1010 p=%0d b=0 s=0 d=0",
                         k, freq_word, phase_word, busy, step_strobe, sweep_done, ph);
            end
            tick();
        end
        test_single_sweep(1030, 1000, 20, 0, "after_abort");
    endtask

    task automatic test_reset_mid;
        launch(100, 5000, 7, 3, 1'b0, 1234);
        repeat (5) tick();
        #2 sys_rst_n = 1'b0;
        #1;
        tests_run++;
        if ({freq_word, phase_word, busy, step_strobe, sweep_done} !== '0) begin
            tests_failed++;
            $display("FAIL reset_async got f=%0d p=%0d b=%b s=%b d=%b want all 0",
                     freq_word, phase_word, busy, step_strobe, sweep_done);
        end
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests_run++;
            if ({freq_word, phase_word, busy, step_strobe, sweep_done} !== '0) begin
                tests_failed++;
                $display("FAIL reset_hold cyc%0d got f=%0d b=%b s=%b want all 0", k, freq_word, busy, step_strobe);
            end
        end
        start = 1'b0;
        sys_rst_n = 1'b1;
        tick();
        tick();
        tests_run++;
        if ({freq_word, busy, step_strobe, sweep_done} !== '0) begin
            tests_failed++;
            $display("FAIL reset_release got f=%0d b=%b s=%b d=%b want all 0", freq_word, busy, step_strobe, sweep_done);
        end
        test_single_sweep(200, 230, 0, 1, "after_reset");
    endtask

    initial begin
        test_reset();
        test_single_sweep(1000, 1030, 10, 2, "up_1000_1030");
        test_single_sweep(1030, 1000, 20, 0, "down_1030_1000");
        test_single_sweep(4321, 4321, 5, 3, "one_word");
        test_single_sweep(10, 0, 0, 0, "down_step0");
        test_single_sweep(65500, 65535, 30000, 1, "up_top_edge");
        test_continuous();
        test_abort();
        test_reset_mid();
        test_random_single();
`ifdef DDS_SWEEP_TRIANGLE_EN
        test_single_sweep(0, 30, 10, 1, "triangle");
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dds_sweep_ctrl.md
DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 SHALL have parameter FW, default 16, giving the frequency/phase word width.
REQ-002 SHALL have parameter DW, default 24, giving the dwell counter width.
REQ-003 SHALL have port sys_clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port sys_rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, sweep start request, sampled each cycle.
REQ-006 SHALL have port abort, input, 1, sweep abort request.
REQ-007 SHALL have port cfg_start_freq, input, FW, first frequency word of the sweep.
REQ-008 SHALL have port cfg_stop_freq, input, FW, last frequency word of the sweep.
REQ-009 SHALL have port cfg_step, input, FW, frequency increment per step.
REQ-010 SHALL have port cfg_dwell, input, DW, hold time per word minus one, in cycles.
REQ-011 SHALL have port cfg_continuous, input, 1, 1 = repeat sweep, 0 = single sweep.
REQ-012 SHALL have port cfg_phase, input, FW, phase offset word for the downstream DDS.
REQ-013 SHALL have port freq_word, output, FW, registered frequency control word to the DDS.
REQ-014 SHALL have port phase_word, output, FW, registered phase control word to the DDS.
REQ-015 SHALL have port busy, output, 1, high while the sweep is running.
REQ-016 SHALL have port step_strobe, output, 1, one-cycle pulse whenever freq_word is updated.
REQ-017 SHALL have port sweep_done, output, 1, one-cycle pulse when a single sweep ends.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE at end of a single sweep, DONE->IDLE unconditionally after 1 cycle.
REQ-019 SHALL, on start in IDLE, capture all cfg_* into shadow registers and set freq_word=cfg_start_freq and phase_word=cfg_phase on the next edge, with step_strobe=1 and busy=1 from that edge; start SHALL be ignored in RUN and DONE.
REQ-020 SHALL hold each freq_word value for exactly shadow dwell+1 cycles; dwell 0 gives one word per cycle.
REQ-021 SHALL sweep up when start<=stop (next = min(freq+step, stop)) and down when start>stop (next = max(freq-step, stop)); arithmetic SHALL be FW+1 bits so no wrap occurs past 0 or 2^FW-1.
REQ-022 SHALL treat shadow step 0 as step 1.
REQ-023 SHALL, at dwell expiry with freq_word==stop: single mode -> DONE with sweep_done=1 and freq_word held at stop; continuous mode -> freq_word=start and step_strobe=1 on the same edge, staying in RUN.
REQ-024 SHALL, on abort while busy, enter IDLE on the next edge, hold freq_word and phase_word, and emit no sweep_done; abort SHALL take priority over start and over dwell expiry in the same cycle.
REQ-025 SHALL hold busy=1 in RUN only; busy SHALL be 0 in IDLE and DONE.
REQ-026 SHALL treat start==stop as a one-word sweep: hold for dwell+1 cycles, then end per REQ-023.

Reset
REQ-027 SHALL, while sys_rst_n=0, force state IDLE and freq_word, phase_word, busy, step_strobe, sweep_done and all shadow/counter registers to 0, regardless of the clock.
REQ-028 SHALL, on reset mid-sweep, resume only on a new start after reset release.

Configuration
REQ-029 SHALL support macro DDS_SWEEP_TRIANGLE_EN; when defined, reaching stop reverses direction toward start (triangle sweep), a single sweep ending at dwell expiry on start, continuous mode reversing at both ends; when undefined, REQ-023 sawtooth behaviour applies.

Structure
REQ-030 SHALL take the FSM state enum, FW/DW defaults and direction encoding from the shared package dds_pkg.
REQ-031 SHALL instantiate one sub-module dds_dwell_timer (load, count down, expire pulse) for the dwell counter.

Verification
REQ-032 SHALL check: start=1000, stop=1030, step=10, dwell=2, single -> words 1000,1010,1020,1030 each 3 cycles, then sweep_done 1 cycle, busy 0.
REQ-033 SHALL check: start=1030, stop=1000, step=20, dwell=0 -> 1030,1010,1000, then done; no value below 1000.
REQ-034 SHALL check: start=65530, stop=65535, step=4, continuous -> 65530,65534,65535,65530,...; no wrap to low values.
REQ-035 SHALL check: abort asserted with start in 3rd dwell cycle of word 2 -> IDLE next edge, freq_word frozen, no sweep_done, next start accepted.
REQ-036 SHALL check: with DDS_SWEEP_TRIANGLE_EN, start=0, stop=30, step=10, single -> 0,10,20,30,20,10,0, then done.
REQ-037 SHALL check: sys_rst_n low mid-sweep -> all outputs 0 immediately without a clock edge; start ignored until release.
